imm_decode_pipe: RTL

Pipelined, parametrised immediate decoder for the decode stage. Accepts one 32-bit RV instruction per cycle over a valid/ready handshake and returns the sign-extended immediate at XLEN width, with a format code and an illegal-opcode flag. Covers all RV32I/RV64I base formats, including sign-extended J-type. Sits between fetch and the register-read/ALU operand mux, and absorbs backpressure with an optional skid buffer.

---
 rtl/imm_decode_pipe_if.sv | 24 ++
 rtl/imm_decode_pipe.sv | 93 +++++++++
 2 files changed

// File: rtl/imm_decode_pipe_if.sv
// imm_decode_pipe_if: instruction-in / immediate-out valid-ready bundle for imm_decode_pipe
interface imm_decode_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_instr_i;
  logic [XLEN-1:0] in_pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_imm_o;
  logic [2:0]      out_fmt_o;
  logic            out_illegal_o;
  logic [31:0]     out_instr_o;
  logic [XLEN-1:0] out_pc_o;
  modport master (
    output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_imm_o, out_fmt_o, out_illegal_o, out_instr_o, out_pc_o
  );
  modport slave (
    input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_imm_o, out_fmt_o, out_illegal_o, out_instr_o, out_pc_o
  );
endinterface

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: RV32I/RV64I immediate decoder with a 2-entry skid buffer or single output stage
module imm_decode_pipe #(
  parameter int XLEN     = 32,
  parameter bit BUFFERED = 1
) (
  input logic clk_i,
  input logic rst_i,
  input logic flush_i,
  imm_decode_pipe_if.slave io
);
  localparam logic [2:0] FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;
  entry_t mem_q [2];
  entry_t mem_d [2];
  entry_t dec;
  logic [1:0] count_q, count_d;
  logic head_q, head_d, wr_idx, push, pop;
  logic [31:0] ins;
  logic signed [31:0] imm32;
  assign ins = io.in_instr_i;
  // decode to a sign-extended 32-bit value first; the signed cast widens it for RV64
  always_comb begin
    imm32 = '0;
    dec = '0;
    dec.instr = ins;
    dec.pc = io.in_pc_i;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0011011: begin
        dec.fmt = XLEN == 64 ? FMT_I : FMT_NONE;
        dec.illegal = XLEN != 64;
        imm32 = XLEN == 64 ? {{20{ins[31]}}, ins[31:20]} : '0;
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32 = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b0110011: dec.illegal = 1'b0;
      7'b0111011: dec.illegal = XLEN != 64;
      default:    dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'(imm32);
  end
  // unbuffered mode keeps head and write slot pinned at entry 0
  always_comb begin
    push = io.in_valid_i && io.in_ready_o && !flush_i;
    pop = io.out_valid_o && io.out_ready_i && !flush_i;
    wr_idx = BUFFERED ? head_q ^ count_q[0] : 1'b0;
    mem_d = mem_q;
    if (push) mem_d[wr_idx] = dec;
    head_d = BUFFERED && pop ? !head_q : head_q;
    count_d = flush_i ? 2'd0 : count_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      count_q <= '0;
      head_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      count_q <= count_d;
      head_q <= head_d;
    end
  end
  assign io.in_ready_o = !rst_i && (BUFFERED ? !count_q[1] : (count_q == 2'd0 || io.out_ready_i));
  assign io.out_valid_o = count_q != 2'd0;
  assign io.out_imm_o = mem_q[head_q].imm;
  assign io.out_fmt_o = mem_q[head_q].fmt;
  assign io.out_illegal_o = mem_q[head_q].illegal;
  assign io.out_instr_o = mem_q[head_q].instr;
  assign io.out_pc_o = mem_q[head_q].pc;
endmodule
